// File: rtl/clkdiv_align_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : clkdiv_align_ctrl                                                 |
// | Brief  : Resets, settles and bit-slips the fabric clock divider until the  |
// |          external phase detector reports PHASE_OK, or the slips run out.   |
// |          Optional macro CLKDIV_AUTO_RETRY_EN: a phase loss while LOCKED    |
// |          restarts the alignment sequence automatically.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module clkdiv_align_ctrl #(
   parameter int RST_CYCLES    = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int SLIP_GAP      = 8,
   parameter int MAX_SLIPS     = 3,
   parameter int CNT_W         = 8,
   parameter int SC_W          = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            phase_ok,
   output logic            div_rst_n,
   output logic            div_bit_slip,
   output logic            busy,
   output logic            locked,
   output logic            fail,
   output logic [SC_W-1:0] slip_cnt
);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_reset  = 3'd1;
   localparam logic [2:0] c_st_settle = 3'd2;
   localparam logic [2:0] c_st_check  = 3'd3;
   localparam logic [2:0] c_st_slip   = 3'd4;
   localparam logic [2:0] c_st_gap    = 3'd5;
   localparam logic [2:0] c_st_locked = 3'd6;
   localparam logic [2:0] c_st_fail   = 3'd7;

   localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_gap_last    = CNT_W'(SLIP_GAP - 1);
   localparam logic [SC_W-1:0]  c_max_slips   = SC_W'(MAX_SLIPS);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_rst_n_q, div_rst_n_d;
   logic             div_bit_slip_q, div_bit_slip_d;
   logic             busy_q, busy_d;
   logic             locked_q, locked_d;
   logic             fail_q, fail_d;
   logic [SC_W-1:0]  slip_cnt_q, slip_cnt_d;
   logic             w_auto_retry;

`ifdef CLKDIV_AUTO_RETRY_EN
   assign w_auto_retry = (state_q == c_st_locked) && !phase_ok;
`else
   assign w_auto_retry = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= c_st_idle;
         cnt_q          <= '0;
         div_rst_n_q    <= 1'b1;
         div_bit_slip_q <= 1'b0;
         busy_q         <= 1'b0;
         locked_q       <= 1'b0;
         fail_q         <= 1'b0;
         slip_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         div_rst_n_q    <= div_rst_n_d;
         div_bit_slip_q <= div_bit_slip_d;
         busy_q         <= busy_d;
         locked_q       <= locked_d;
         fail_q         <= fail_d;
         slip_cnt_q     <= slip_cnt_d;
      end
   end

   // The delay counter is cleared on every timed-state exit so each timed state starts at 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         c_st_idle, c_st_locked, c_st_fail: begin
            if (start || w_auto_retry) begin
               state_d = c_st_reset;
               cnt_d   = '0;
            end
         end
         c_st_reset: begin
            if (cnt_q == c_rst_last) begin
               state_d = c_st_settle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         c_st_settle: begin
            if (cnt_q == c_settle_last) begin
               state_d = c_st_check;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         c_st_check: begin
            cnt_d = '0;
            if (phase_ok) begin
               state_d = c_st_locked;
            end else if (slip_cnt_q < c_max_slips) begin
               state_d = c_st_slip;
            end else begin
               state_d = c_st_fail;
            end
         end
         c_st_slip: begin
            state_d = c_st_gap;
            cnt_d   = '0;
         end
         c_st_gap: begin
            if (cnt_q == c_gap_last) begin
               state_d = c_st_check;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = c_st_idle;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      div_rst_n_d    = (state_d != c_st_reset);
      div_bit_slip_d = (state_d == c_st_slip);
      busy_d         = (state_d != c_st_idle) && (state_d != c_st_locked) &&
                       (state_d != c_st_fail);
      locked_d       = (state_d == c_st_locked);
      fail_d         = (state_d == c_st_fail);
      slip_cnt_d     = slip_cnt_q;
      if (state_d == c_st_reset) begin
         slip_cnt_d = '0;
      end else if (state_d == c_st_slip) begin
         slip_cnt_d = slip_cnt_q + SC_W'(1);
      end
   end

   assign div_rst_n    = div_rst_n_q;
   assign div_bit_slip = div_bit_slip_q;
   assign busy         = busy_q;
   assign locked       = locked_q;
   assign fail         = fail_q;
   assign slip_cnt     = slip_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_align_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_clkdiv_align_ctrl                                              |
// | Brief  : Scoreboard bench; expected outputs come from an attempt timeline  |
// |          model computed arithmetically from the alignment rules.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_clkdiv_align_ctrl;

   localparam int RST_C     = 8;
   localparam int SETTLE_C  = 16;
   localparam int GAP_C     = 8;
   localparam int MAX_S     = 3;
   localparam int FIRST_CHK = 1 + RST_C + SETTLE_C;
   localparam int PERIOD    = GAP_C + 2;

   typedef struct packed {
      logic       div_rst_n;
      logic       slip;
      logic       busy;
      logic       locked;
      logic       fail;
      logic [1:0] slip_cnt;
   } out_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       phase_ok = 1'b0;
   logic       div_rst_n, div_bit_slip, busy, locked, fail;
   logic [1:0] slip_cnt;

   out_t exp_q[$];
   out_t rest_out;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   clkdiv_align_ctrl #(
      .RST_CYCLES   (RST_C),
      .SETTLE_CYCLES(SETTLE_C),
      .SLIP_GAP     (GAP_C),
      .MAX_SLIPS    (MAX_S),
      .CNT_W        (8),
      .SC_W         (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .phase_ok    (phase_ok),
      .div_rst_n   (div_rst_n),
      .div_bit_slip(div_bit_slip),
      .busy        (busy),
      .locked      (locked),
      .fail        (fail),
      .slip_cnt    (slip_cnt)
   );

   function automatic out_t idle_out();
      out_t o;
      o = '0;
      o.div_rst_n = 1'b1;
      return o;
   endfunction

   // Outputs in cycle t of an attempt whose START was held during cycle 0.
   function automatic out_t attempt_out(input int t, input int n, input bit lock);
      out_t o;
      int   e;
      e = FIRST_CHK + 1 + n * PERIOD;
      o.div_rst_n = !(t >= 1 && t <= RST_C);
      o.busy      = (t < e);
      o.locked    = (t >= e) && lock;
      o.fail      = (t >= e) && !lock;
      o.slip      = (t < e) && (t >= FIRST_CHK + 1) && (((t - FIRST_CHK - 1) % PERIOD) == 0);
      if (t >= e)                 o.slip_cnt = 2'(n);
      else if (t >= FIRST_CHK + 1) o.slip_cnt = 2'((t - FIRST_CHK - 1) / PERIOD + 1);
      else                        o.slip_cnt = 2'd0;
      return o;
   endfunction

   task automatic step(input bit s, input bit p, input bit r, input out_t x);
      @(negedge clk);
      start    = s;
      phase_ok = p;
      rst_n    = r;
      exp_q.push_back(x);
   endtask

   // j = number of slips after which PHASE_OK is reported good (j > MAX_S never passes).
   task automatic attempt(input int j, input int hold, input bit via_phase,
                          input int rst_at, input int dup_at);
      int n, e, last;
      bit lock;
      n    = (j > MAX_S) ? MAX_S : j;
      lock = (j <= MAX_S);
      e    = FIRST_CHK + 1 + n * PERIOD;
      last = (rst_at >= 0) ? rst_at + hold : e + hold - 1;
      for (int t = 0; t <= last; t++) begin
         bit   s, p;
         out_t x;
         s = ((t == 0) && !via_phase) || (t == dup_at);
         if (t == 0 && via_phase)
            p = 1'b0;
         else if (t >= FIRST_CHK && ((t - FIRST_CHK) % PERIOD) == 0 && ((t - FIRST_CHK) / PERIOD) <= n)
            p = (((t - FIRST_CHK) / PERIOD) >= j);
         else if (t >= e && lock)
`ifdef CLKDIV_AUTO_RETRY_EN
            p = 1'b1;
`else
            p = 1'($urandom_range(0, 1));
`endif
         else
            p = 1'($urandom_range(0, 1));
         x = (rst_at >= 0 && t >= rst_at) ? idle_out() : attempt_out(t + 1, n, lock);
         step(s, p, (t != rst_at), x);
      end
      rest_out = (rst_at >= 0) ? idle_out() : attempt_out(e, n, lock);
   endtask

   initial begin : monitor
      out_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.div_rst_n = div_rst_n;
            a.slip      = div_bit_slip;
            a.busy      = busy;
            a.locked    = locked;
            a.fail      = fail;
            a.slip_cnt  = slip_cnt;
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL outputs @%0t {rst_n,slip,busy,locked,fail,cnt}: got %b want %b",
                        $time, a, e);
            end
         end
      end
   end

   initial begin : stimulus
      int j, hold, dup, rst_at, e;
      repeat (3) step(1'b0, 1'b0, 1'b0, idle_out());
      rest_out = idle_out();
      repeat (3) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, idle_out());

      attempt(0, 4, 1'b0, -1, -1);   // immediate lock
      attempt(2, 4, 1'b0, -1, -1);   // lock after two slips, started from LOCKED
      attempt(4, 4, 1'b0, -1, -1);   // never good -> FAIL
      attempt(1, 4, 1'b0, -1, -1);   // restart from FAIL
      attempt(0, 3, 1'b0, 15, -1);   // reset during SETTLE
      attempt(0, 3, 1'b0, -1, 5);    // START while busy is dropped
      attempt(3, 3, 1'b0, 0, -1);    // START and reset together: reset wins
      attempt(3, 4, 1'b0, -1, -1);   // lock on the last permitted check

`ifdef CLKDIV_AUTO_RETRY_EN
      attempt(1, 4, 1'b1, -1, -1);
`else
      step(1'b0, 1'b0, 1'b1, rest_out);
      repeat (5) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, rest_out);
`endif

      repeat (12) begin
         j      = $urandom_range(0, 4);
         hold   = $urandom_range(1, 5);
         e      = FIRST_CHK + 1 + ((j > MAX_S) ? MAX_S : j) * PERIOD;
         dup    = ($urandom_range(0, 1) == 1) ? $urandom_range(2, e - 1) : -1;
         rst_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, e - 1) : -1;
         if (rst_at >= 0 && dup >= rst_at) dup = -1;
         attempt(j, hold, 1'b0, rst_at, dup);
      end

      repeat (2) step(1'b0, 1'b1, 1'b1, rest_out);
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
